// File: rtl/mod_add_vec_ctrl_if.sv
// Bus bundle for mod_add_vec_ctrl: control handshake, operand read port and result write port.
// The sub signal exists only when MOD_ADD_VEC_SUB_EN is defined.
interface mod_add_vec_ctrl_if #(
  parameter int K  = 8,
  parameter int AW = 4
);
  logic          start;
  logic [AW:0]   len;
  logic [K-1:0]  modulus;
`ifdef MOD_ADD_VEC_SUB_EN
  logic          sub;
`endif
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [K-1:0]  rd_a;
  logic [K-1:0]  rd_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [K-1:0]  wr_data;

`ifdef MOD_ADD_VEC_SUB_EN
  modport master (
    input  start, len, modulus, sub, rd_a, rd_b,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
  modport slave (
    output start, len, modulus, sub, rd_a, rd_b,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
`else
  modport master (
    input  start, len, modulus, rd_a, rd_b,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
  modport slave (
    output start, len, modulus, rd_a, rd_b,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
`endif
endinterface

// File: rtl/mod_add_vec_ctrl.sv
// Sequencer streaming C[i] = (A[i] +/- B[i]) mod M over a vector, one element per cycle.
// Define MOD_ADD_VEC_SUB_EN to add the latched sub (modular subtraction) mode.
module mod_add_vec_ctrl #(
  parameter int K  = 8,
  parameter int AW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_add_vec_ctrl_if.master   bus
);

  localparam logic [AW:0] N = (AW+1)'(1 << AW);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nx;
  logic [AW:0]   len_q;
  logic [K-1:0]  mod_q;
  logic [AW-1:0] cnt;
  logic [AW:0]   len_eff;
  logic          take_start;
  logic          last_rd;
  logic          rd_en;
  logic          vld_p1;
  logic [AW-1:0] addr_p1;
  logic          wr_en_p2;
  logic [AW-1:0] wr_addr_p2;
  logic [K-1:0]  wr_data_p2;
`ifdef MOD_ADD_VEC_SUB_EN
  logic          sub_q;
`endif

  function automatic logic [K-1:0] mod_add(input logic [K-1:0] a, input logic [K-1:0] b,
                                           input logic [K-1:0] m);
    logic [K:0] s;
    logic [K:0] d;
    s = {1'b0, a} + {1'b0, b};
    d = s - {1'b0, m};
    return (s >= {1'b0, m}) ? d[K-1:0] : s[K-1:0];
  endfunction

`ifdef MOD_ADD_VEC_SUB_EN
  function automatic logic [K-1:0] mod_sub(input logic [K-1:0] a, input logic [K-1:0] b,
                                           input logic [K-1:0] m);
    logic [K:0] t;
    logic [K:0] u;
    t = {1'b0, a} - {1'b0, b};
    u = t + {1'b0, m};
    return t[K] ? u[K-1:0] : t[K-1:0];
  endfunction
`endif

  assign len_eff    = (bus.len > N) ? N : bus.len;
  // A new run may be accepted in the DONE cycle as well, giving back-to-back runs.
  assign take_start = bus.start && ((state == IDLE) || (state == DONE));
  assign last_rd    = (state == RUN) && ({1'b0, cnt} == (len_q - (AW+1)'(1)));
  assign rd_en      = (state == RUN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (take_start)          state_nx = (len_eff != '0) ? RUN : DONE;
        else if (state == DONE)  state_nx = IDLE;
      end
      RUN:     if (last_rd) state_nx = DRAIN;
      DRAIN:   if (!vld_p1) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      mod_q <= '0;
      cnt   <= '0;
`ifdef MOD_ADD_VEC_SUB_EN
      sub_q <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (take_start) begin
        len_q <= len_eff;
        mod_q <= bus.modulus;
        cnt   <= '0;
`ifdef MOD_ADD_VEC_SUB_EN
        sub_q <= bus.sub;
`endif
      end else if (rd_en && !last_rd) begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  // Stage 1: valid/address of the operand data returning this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= rd_en;
      addr_p1 <= cnt;
    end
  end

  // Stage 2: registered modular result and write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_p2   <= 1'b0;
      wr_addr_p2 <= '0;
      wr_data_p2 <= '0;
    end else begin
      wr_en_p2   <= vld_p1;
      wr_addr_p2 <= addr_p1;
      if (vld_p1) begin
`ifdef MOD_ADD_VEC_SUB_EN
        wr_data_p2 <= sub_q ? mod_sub(bus.rd_a, bus.rd_b, mod_q)
                            : mod_add(bus.rd_a, bus.rd_b, mod_q);
`else
        wr_data_p2 <= mod_add(bus.rd_a, bus.rd_b, mod_q);
`endif
      end
    end
  end

  assign bus.busy    = (state == RUN) || (state == DRAIN);
  assign bus.done    = (state == DONE);
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_en ? cnt : '0;
  assign bus.wr_en   = wr_en_p2;
  assign bus.wr_addr = wr_addr_p2;
  assign bus.wr_data = wr_data_p2;

endmodule
